// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC FSM state encoding and default vectors.
package cpu_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0040_0004;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC / next-state priority mux for pc_unit.
// Misaligned-redirect trapping is enabled by defining PC_ALIGN_CHECK_EN.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int          PC_W    = 32,
  parameter logic [31:0] EXC_VEC = DEF_EXC_VEC,
  parameter int          STEP    = 4
) (
  input  pc_state_t        state_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [PC_W-1:0]  redirect_target_i,
  input  logic             exc_valid_i,
  input  logic             halt_i,
  input  logic             resume_i,
  input  logic             fetch_ready_i,
  output logic [PC_W-1:0]  pc_d_o,
  output pc_state_t        state_d_o,
  output logic             misalign_d_o
);

  localparam logic [PC_W-1:0] EXC_PC   = PC_W'(EXC_VEC);
  localparam logic [PC_W-1:0] STEP_INC = PC_W'(STEP);

  logic redir_bad;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(STEP - 1);
  assign redir_bad = |(redirect_target_i & ALIGN_MASK);
`else
  assign redir_bad = 1'b0;
`endif

  always_comb begin
    pc_d_o       = pc_i;
    state_d_o    = state_i;
    misalign_d_o = 1'b0;
    case (state_i)
      // Control inputs are deliberately ignored during the single boot cycle.
      ST_BOOT: state_d_o = ST_RUN;
      ST_RUN: begin
        if (exc_valid_i) begin
          pc_d_o = EXC_PC;
        end else if (redirect_valid_i) begin
          if (redir_bad) begin
            pc_d_o       = EXC_PC;
            misalign_d_o = 1'b1;
          end else begin
            pc_d_o = redirect_target_i;
          end
        end else if (halt_i) begin
          state_d_o = ST_HALT;
        end else if (!stall_i && fetch_ready_i) begin
          pc_d_o = pc_i + STEP_INC;
        end
      end
      ST_HALT: begin
        if (exc_valid_i) begin
          pc_d_o    = EXC_PC;
          state_d_o = ST_RUN;
        end else if (resume_i) begin
          state_d_o = ST_RUN;
        end
      end
      default: state_d_o = ST_BOOT;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC/FSM registers and the instruction fetch request.
// Optional misaligned-redirect trap via PC_ALIGN_CHECK_EN (see pc_next_sel).
module pc_unit
  import cpu_pkg::*;
#(
  parameter int          PC_W      = 32,
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int          STEP      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_target,
  input  logic                exc_valid,
  input  logic                halt,
  input  logic                resume,
  input  logic                fetch_ready,
  output logic                fetch_valid,
  output logic [PC_W-1:0]     fetch_pc,
  output logic [PC_W-1:0]     pc,
  output logic [STATE_W-1:0]  state,
  output logic                misalign_err
);

  localparam logic [PC_W-1:0] RESET_PC = PC_W'(RESET_VEC);

  logic [PC_W-1:0] pc_q, pc_d;
  pc_state_t       state_q, state_d;
  logic            misalign_q, misalign_d;

  pc_next_sel #(
    .PC_W    (PC_W),
    .EXC_VEC (EXC_VEC),
    .STEP    (STEP)
  ) u_next_sel (
    .state_i           (state_q),
    .pc_i              (pc_q),
    .stall_i           (stall),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .exc_valid_i       (exc_valid),
    .halt_i            (halt),
    .resume_i          (resume),
    .fetch_ready_i     (fetch_ready),
    .pc_d_o            (pc_d),
    .state_d_o         (state_d),
    .misalign_d_o      (misalign_d)
  );

  // Async reset abandons any outstanding fetch request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      state_q    <= ST_BOOT;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      misalign_q <= misalign_d;
    end
  end

  assign fetch_valid  = (state_q == ST_RUN);
  assign fetch_pc     = pc_q;
  assign pc           = pc_q;
  assign state        = state_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (default 32-bit and 8-bit wrap instances).
module tb_pc_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Instance A: default parameters
  logic        rst, stall, redirect_valid, exc_valid, halt, resume, fetch_ready;
  logic [31:0] redirect_target;
  logic        fetch_valid, misalign_err;
  logic [31:0] fetch_pc, pc;
  logic [1:0]  state;

  pc_unit u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .exc_valid(exc_valid), .halt(halt),
    .resume(resume), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .pc(pc), .state(state), .misalign_err(misalign_err)
  );

  // Instance B: 8-bit PC near the top of the address space
  logic       rst_b, ready_b;
  logic       fv_b, me_b;
  logic [7:0] fpc_b, pc_b;
  logic [1:0] st_b;

  pc_unit #(.PC_W(8), .RESET_VEC(32'h0000_00F8)) u_dut8 (
    .clk(clk), .rst(rst_b), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_target(8'h00), .exc_valid(1'b0), .halt(1'b0),
    .resume(1'b0), .fetch_ready(ready_b), .fetch_valid(fv_b),
    .fetch_pc(fpc_b), .pc(pc_b), .state(st_b), .misalign_err(me_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 0; redirect_valid = 0; exc_valid = 0; halt = 0;
    resume = 0; fetch_ready = 1; redirect_target = '0;
    step(); step();
    tests++; if (pc !== 32'h0040_0000) begin $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0040_0000); failed++; end
    tests++; if (state !== 2'd0) begin $display("FAIL rst_state got=%0d exp=0", state); failed++; end
    tests++; if (fetch_valid !== 1'b0) begin $display("FAIL rst_fv got=%b exp=0", fetch_valid); failed++; end
    tests++; if (misalign_err !== 1'b0) begin $display("FAIL rst_me got=%b exp=0", misalign_err); failed++; end
    rst = 1'b0;
    // exc/redirect during BOOT must be ignored
    exc_valid = 1; redirect_valid = 1; redirect_target = 32'h0070_0000;
    #1;
    tests++; if (state !== 2'd0 || fetch_valid !== 1'b0) begin $display("FAIL boot got st=%0d fv=%b exp st=0 fv=0", state, fetch_valid); failed++; end
    step();
    exc_valid = 0; redirect_valid = 0;
    tests++; if (state !== 2'd1 || fetch_pc !== 32'h0040_0000 || fetch_valid !== 1'b1) begin
      $display("FAIL boot_exit got st=%0d pc=%h fv=%b exp st=1 pc=00400000 fv=1", state, fetch_pc, fetch_valid); failed++; end
    step();
    tests++; if (fetch_pc !== 32'h0040_0004) begin $display("FAIL seq1 got=%h exp=00400004", fetch_pc); failed++; end
    step();
    tests++; if (fetch_pc !== 32'h0040_0008) begin $display("FAIL seq2 got=%h exp=00400008", fetch_pc); failed++; end
  endtask

  task automatic test_backpressure();
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (pc !== 32'h0040_0008 || fetch_valid !== 1'b1) begin
        $display("FAIL bp_hold%0d got pc=%h fv=%b exp pc=00400008 fv=1", i, pc, fetch_valid); failed++; end
    end
    fetch_ready = 1;
    step();
    tests++; if (pc !== 32'h0040_000C) begin $display("FAIL bp_release got=%h exp=0040000c", pc); failed++; end
    stall = 1;
    step();
    tests++; if (pc !== 32'h0040_000C) begin $display("FAIL stall_hold got=%h exp=0040000c", pc); failed++; end
  endtask

  task automatic test_redirect();
    redirect_valid = 1; redirect_target = 32'h0040_1000;
    step();
    tests++; if (pc !== 32'h0040_1000) begin $display("FAIL redir_stall got=%h exp=00401000", pc); failed++; end
    redirect_target = 32'h0040_2000; exc_valid = 1;
    step();
    tests++; if (pc !== 32'h0040_0004) begin $display("FAIL exc_over_redir got=%h exp=00400004", pc); failed++; end
    exc_valid = 0; stall = 0; fetch_ready = 0;
    redirect_target = 32'h0040_0010; halt = 1;
    step();
    tests++; if (pc !== 32'h0040_0010 || state !== 2'd1) begin
      $display("FAIL redir_halt got pc=%h st=%0d exp pc=00400010 st=1", pc, state); failed++; end
    redirect_valid = 0; fetch_ready = 1;
  endtask

  task automatic test_halt();
    step();
    tests++; if (state !== 2'd2 || fetch_valid !== 1'b0 || pc !== 32'h0040_0010) begin
      $display("FAIL halt_enter got st=%0d fv=%b pc=%h exp st=2 fv=0 pc=00400010", state, fetch_valid, pc); failed++; end
    halt = 0; redirect_valid = 1; redirect_target = 32'h0050_0000;
    step();
    tests++; if (state !== 2'd2 || pc !== 32'h0040_0010) begin
      $display("FAIL halt_redir got st=%0d pc=%h exp st=2 pc=00400010", state, pc); failed++; end
    redirect_valid = 0; resume = 1;
    step();
    resume = 0;
    tests++; if (state !== 2'd1 || fetch_valid !== 1'b1 || fetch_pc !== 32'h0040_0010) begin
      $display("FAIL resume got st=%0d fv=%b pc=%h exp st=1 fv=1 pc=00400010", state, fetch_valid, fetch_pc); failed++; end
    step();
    tests++; if (pc !== 32'h0040_0014) begin $display("FAIL resume_seq got=%h exp=00400014", pc); failed++; end
    halt = 1;
    step();
    halt = 0; exc_valid = 1;
    tests++; if (state !== 2'd2 || pc !== 32'h0040_0014) begin
      $display("FAIL halt2 got st=%0d pc=%h exp st=2 pc=00400014", state, pc); failed++; end
    step();
    exc_valid = 0;
    tests++; if (state !== 2'd1 || pc !== 32'h0040_0004) begin
      $display("FAIL halt_exc got st=%0d pc=%h exp st=1 pc=00400004", state, pc); failed++; end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    logic        exp_me;
`ifdef PC_ALIGN_CHECK_EN
    exp_pc = 32'h0040_0004; exp_me = 1'b1;
`else
    exp_pc = 32'h0040_1002; exp_me = 1'b0;
`endif
    redirect_valid = 1; redirect_target = 32'h0040_1002;
    step();
    redirect_valid = 0;
    tests++; if (pc !== exp_pc || misalign_err !== exp_me) begin
      $display("FAIL misalign got pc=%h me=%b exp pc=%h me=%b", pc, misalign_err, exp_pc, exp_me); failed++; end
    step();
    tests++; if (misalign_err !== 1'b0 || pc !== exp_pc + 32'd4) begin
      $display("FAIL misalign_pulse got pc=%h me=%b exp pc=%h me=0", pc, misalign_err, exp_pc + 32'd4); failed++; end
    exc_valid = 1; redirect_valid = 1;
    step();
    exc_valid = 0; redirect_valid = 0;
    tests++; if (pc !== 32'h0040_0004 || misalign_err !== 1'b0) begin
      $display("FAIL misalign_exc got pc=%h me=%b exp pc=00400004 me=0", pc, misalign_err); failed++; end
  endtask

  task automatic test_wrap();
    ready_b = 1;
    step();
    rst_b = 0;
    step();
    tests++; if (pc_b !== 8'hF8 || st_b !== 2'd1) begin $display("FAIL wrap0 got pc=%h st=%0d exp pc=f8 st=1", pc_b, st_b); failed++; end
    step();
    tests++; if (pc_b !== 8'hFC) begin $display("FAIL wrap1 got=%h exp=fc", pc_b); failed++; end
    step();
    tests++; if (pc_b !== 8'h00 || me_b !== 1'b0) begin $display("FAIL wrap2 got pc=%h me=%b exp pc=00 me=0", pc_b, me_b); failed++; end
    ready_b = 0;
    step();
    tests++; if (pc_b !== 8'h00 || fv_b !== 1'b1) begin $display("FAIL wrap_pend got pc=%h fv=%b exp pc=00 fv=1", pc_b, fv_b); failed++; end
    #2 rst_b = 1;
    #1;
    tests++; if (pc_b !== 8'hF8 || fv_b !== 1'b0 || st_b !== 2'd0 || fpc_b !== 8'hF8) begin
      $display("FAIL async_rst got pc=%h fv=%b st=%0d exp pc=f8 fv=0 st=0", pc_b, fv_b, st_b); failed++; end
  endtask

  initial begin
    rst_b = 1; ready_b = 0;
    test_reset();
    test_backpressure();
    test_redirect();
    test_halt();
    test_misalign();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the single-register PC latch.
- Owns the fetch PC and selects the next PC from: reset vector, exception vector, branch/jump redirect, hold (stall/handshake) or sequential increment.
- Drives a valid/ready fetch request to instruction memory and has a small run/halt state machine.
- Sits between the control unit (redirect, exception, stall, halt) and the instruction-memory port.

Parameters:
- PC_W, 32, PC width in bits (≥8).
- RESET_VEC, 32'h0040_0000, PC value loaded on reset; truncated to PC_W.
- EXC_VEC, 32'h0040_0004, PC loaded on an exception; truncated to PC_W.
- STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- stall  input  1  pipeline stall; hold PC.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  PC_W  target PC for a redirect.
- exc_valid  input  1  exception/interrupt entry.
- halt  input  1  request to stop fetching.
- resume  input  1  leave the HALT state.
- fetch_ready  input  1  instruction memory accepts the request.
- fetch_valid  output  1  fetch request valid.
- fetch_pc  output  PC_W  address of the fetch request; equals pc.
- pc  output  PC_W  current PC register.
- state  output  2  FSM state for debug: 0=BOOT, 1=RUN, 2=HALT.
- misalign_err  output  1  one-cycle pulse when a misaligned redirect is detected (optional feature; 0 otherwise).

Behaviour:
- Reset (asynchronous, effective immediately):
  - pc = RESET_VEC, state = BOOT, fetch_valid = 0, misalign_err = 0.
- BOOT: lasts exactly one cycle after rst deasserts.
  - fetch_valid = 0, pc holds.
  - Next state: RUN.
  - exc_valid/redirect_valid are ignored in this cycle.
- RUN: fetch_valid = 1. Next-PC priority, highest first:
  1. exc_valid → pc = EXC_VEC.
  2. redirect_valid → pc = redirect_target.
  3. halt → pc holds; next state = HALT.
  4. stall, or fetch_valid & !fetch_ready → pc holds.
  5. Otherwise (handshake completes) → pc = pc + STEP, modulo 2^PC_W; all-ones wraps to low values, no error.
- exc_valid and redirect_valid override both stall and a pending handshake:
  - An outstanding request is cancelled and fetch_pc changes without waiting for ready.
  - The memory side tolerates this.
- Simultaneous exc_valid + redirect_valid: exception wins, redirect is dropped.
- Simultaneous halt + exc_valid or redirect: the PC update happens and state stays RUN; halt is honoured on a later cycle if still asserted.
- HALT: fetch_valid = 0 and pc holds.
  - resume → RUN next cycle, continuing from the held pc.
  - exc_valid in HALT → pc = EXC_VEC and state = RUN (wake on exception).
  - redirect_valid in HALT is ignored.
- Latency: every PC change is visible on pc/fetch_pc one cycle after the qualifying input edge.
- Reset mid-operation (any state, including a pending handshake): immediate return to reset values; the request is abandoned.
- STEP arithmetic is PC_W-bit unsigned.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect whose target has low bits nonzero (target mod STEP ≠ 0, STEP a power of two) is not taken.
  - pc = EXC_VEC instead, and misalign_err pulses high for one cycle, coincident with the pc update.
  - An exception in the same cycle takes priority, with no error pulse.
- Undefined: the target is taken unmodified and misalign_err is tied 0.

Decomposition:
- Shared package cpu_pkg:
  - FSM state encoding typedef (pc_state_t: BOOT, RUN, HALT).
  - Default RESET_VEC/EXC_VEC constants.
  - Debug state width constant.
- One natural sub-module: pc_next_sel, a combinational priority mux computing next pc and next state. The top keeps the registers.

Test Plan:
- Assert rst, release, hold fetch_ready=1 → pc=0x00400000 with fetch_valid=0 for one cycle, then fetch_pc 0x00400000, 0x00400004, 0x00400008 on consecutive cycles.
- RUN with fetch_ready=0 for 3 cycles, then 1 → pc held at 0x00400008 while valid stays high, then 0x0040000C.
- redirect_valid=1, target=0x00401000 while stall=1 → pc=0x00401000 next cycle; same cycle exc_valid=1 → pc=0x00400004 instead.
- halt=1 at pc=0x00400010 → fetch_valid=0, pc held, state=2; resume=1 → state=1, fetch resumes at 0x00400010; separately exc_valid in HALT → pc=0x00400004, state=1.
- PC_W=8, RESET_VEC=8'hF8 → pc sequence F8, FC, 00; assert rst mid-handshake → pc=F8 immediately, fetch_valid=0.
- With PC_ALIGN_CHECK_EN: redirect to 0x00401002 → pc=0x00400004, misalign_err high for exactly 1 cycle; without the macro → pc=0x00401002, misalign_err=0.
